// File: rtl/fib_result_checker.sv
// Program-level self-check: waits for the core to park on its halt loop, then
// walks data memory and compares each word against a generated Fibonacci sequence.
module fib_result_checker #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 8,
  parameter int N_TERMS        = 10,
  parameter int SEED0          = 1,
  parameter int SEED1          = 1,
  parameter int HALT_PC        = 100,
  parameter int STABLE_CYCLES  = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [XLEN-1:0]                pc,
  output logic                           mem_rd_en,
  output logic [ADDR_W-1:0]              mem_rd_addr,
  input  logic [XLEN-1:0]                mem_rd_data,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic                           timeout,
  output logic [$clog2(N_TERMS+1)-1:0]   err_count,
  output logic [ADDR_W-1:0]              first_err_idx,
  output logic [XLEN-1:0]                first_err_exp,
  output logic [XLEN-1:0]                first_err_act
);

  localparam int ERR_W = $clog2(N_TERMS+1);
  localparam int ST_W  = $clog2(STABLE_CYCLES+1);
  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES+1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_HALT, S_READ, S_CHECK, S_DONE
  } state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   prev_pc;
  logic [ST_W-1:0]   stable, stable_next;
  logic [TMO_W-1:0]  tmo, tmo_next;
  logic [ADDR_W-1:0] idx;
  logic [XLEN-1:0]   fa, fb;
  logic              halt_now, tmo_hit, last_term, mismatch, start_ok;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    stable_next = '0;
    tmo_next    = tmo + TMO_W'(1);
    halt_now    = 1'b0;
    tmo_hit     = 1'b0;
    last_term   = (idx == ADDR_W'(N_TERMS-1));
    mismatch    = (mem_rd_data != fa);
    start_ok    = start && (state == S_IDLE || state == S_DONE);
    if (pc == XLEN'(HALT_PC) && pc == prev_pc) stable_next = stable + ST_W'(1);
    halt_now = (stable_next == ST_W'(STABLE_CYCLES));
    tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_next == TMO_W'(TIMEOUT_CYCLES));

    state_next = state;
    case (state)
      S_IDLE:      if (start) state_next = S_WAIT_HALT;
      S_WAIT_HALT: begin
        // Halt detection takes priority over a timeout in the same cycle.
        if (halt_now)     state_next = S_READ;
        else if (tmo_hit) state_next = S_DONE;
      end
      S_READ:      state_next = S_CHECK;
      S_CHECK:     state_next = last_term ? S_DONE : S_READ;
      S_DONE:      if (start) state_next = S_WAIT_HALT;
      default:     state_next = S_IDLE;
    endcase
  end

  assign busy      = (state == S_WAIT_HALT) || (state == S_READ) || (state == S_CHECK);
  assign done      = (state == S_DONE);
  assign mem_rd_en = (state == S_READ);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc       <= '0;
      stable        <= '0;
      tmo           <= '0;
      idx           <= '0;
      fa            <= '0;
      fb            <= '0;
      mem_rd_addr   <= '0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
    end else if (start_ok) begin
      // All-ones prev_pc guarantees the first watched cycle never counts as stable.
      prev_pc       <= '1;
      stable        <= '0;
      tmo           <= '0;
      idx           <= '0;
      fa            <= XLEN'(SEED0);
      fb            <= XLEN'(SEED1);
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
    end else begin
      case (state)
        S_WAIT_HALT: begin
          prev_pc <= pc;
          stable  <= stable_next;
          if (TIMEOUT_CYCLES != 0) tmo <= tmo_next;
          if (halt_now) mem_rd_addr <= idx;
          else if (tmo_hit) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_count < ERR_W'(N_TERMS)) err_count <= err_count + ERR_W'(1);
            if (err_count == '0) begin
              first_err_idx <= idx;
              first_err_exp <= fa;
              first_err_act <= mem_rd_data;
            end
          end
          fa  <= fb;
          fb  <= fa + fb;
          idx <= idx + ADDR_W'(1);
          if (last_term) pass <= (err_count == '0) && !mismatch;
          else           mem_rd_addr <= idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_result_checker.sv
// Randomized bench for fib_result_checker: a 32-bit default instance and an
// 8-bit/14-term instance that exercises silent wrap of the sequence.
module tb_fib_result_checker;

  localparam int N    = 10;
  localparam int N8   = 14;
  localparam int STB  = 10;
  localparam int TMO  = 1000;
  localparam int HALT = 100;

  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [31:0] pc = 0;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_rd_data = 0;
  logic        busy, done, pass, timeout;
  logic [3:0]  err_count;
  logic [7:0]  first_err_idx;
  logic [31:0] first_err_exp, first_err_act;

  logic        start8 = 0;
  logic [7:0]  pc8 = 0;
  logic        mem_rd_en8;
  logic [7:0]  mem_rd_addr8;
  logic [7:0]  mem_rd_data8 = 0;
  logic        busy8, done8, pass8, timeout8;
  logic [3:0]  err_count8;
  logic [7:0]  first_err_idx8, first_err_exp8, first_err_act8;

  logic [31:0] mem  [0:255];
  logic [7:0]  mem8 [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fib_result_checker dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp), .first_err_act(first_err_act)
  );

  fib_result_checker #(.XLEN(8), .N_TERMS(N8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .pc(pc8),
    .mem_rd_en(mem_rd_en8), .mem_rd_addr(mem_rd_addr8), .mem_rd_data(mem_rd_data8),
    .busy(busy8), .done(done8), .pass(pass8), .timeout(timeout8),
    .err_count(err_count8), .first_err_idx(first_err_idx8),
    .first_err_exp(first_err_exp8), .first_err_act(first_err_act8)
  );

  // Synchronous dmem models: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en)  mem_rd_data  <= mem[mem_rd_addr];
    if (mem_rd_en8) mem_rd_data8 <= mem8[mem_rd_addr8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] fib32(input int i);
    logic [31:0] a = 1, b = 1, t;
    for (int k = 0; k < i; k++) begin t = a + b; a = b; b = t; end
    return a;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = (i < N) ? fib32(i) : 32'hDEAD_0000 + i;
  endtask

  // mode 0: steady halt; 1: toggling 100/104; 2: one-cycle glitch at cycle 10;
  // 3: random noise prefix over {96,100,104} then steady halt.
  task automatic run_main(input string name, input int mode);
    int pc_pat [1:1100];
    int noise_len, halt_c, exp_done_c, first_rd, done_c, exp_err, exp_idx;
    bit exp_tmo, ok;
    logic [31:0] exp_e, exp_a;
    noise_len = $urandom_range(0, 60);
    for (int c = 1; c <= 1100; c++) begin
      case (mode)
        0: pc_pat[c] = HALT;
        1: pc_pat[c] = (c % 2) ? HALT : HALT + 4;
        2: pc_pat[c] = (c == 10) ? HALT - 4 : HALT;
        default: pc_pat[c] = (c <= noise_len) ? HALT - 4 + 4 * $urandom_range(0, 2) : HALT;
      endcase
    end
    // Halt is seen at the first cycle closing a window of STB+1 equal halt PCs.
    halt_c = 0;
    for (int c = STB + 1; c <= TMO && halt_c == 0; c++) begin
      ok = 1;
      for (int k = c - STB; k <= c; k++) if (pc_pat[k] != HALT) ok = 0;
      if (ok) halt_c = c;
    end
    exp_tmo    = (halt_c == 0);
    exp_done_c = exp_tmo ? TMO : halt_c + 2 * N;
    exp_err = 0; exp_idx = 0; exp_e = 0; exp_a = 0;
    if (!exp_tmo)
      for (int i = 0; i < N; i++)
        if (mem[i] != fib32(i)) begin
          if (exp_err == 0) begin exp_idx = i; exp_e = fib32(i); exp_a = mem[i]; end
          exp_err++;
        end

    start = 1;
    @(posedge clk); #1;
    start = 0;
    first_rd = 0; done_c = 0;
    for (int c = 1; c <= 1100; c++) begin
      pc = pc_pat[c];
      @(posedge clk); #1;
      if (mem_rd_en && first_rd == 0) first_rd = c;
      if (done) begin done_c = c; break; end
    end
    check({name, ".done_cycle"}, done_c, exp_done_c);
    check({name, ".first_read"}, first_rd, exp_tmo ? 0 : halt_c);
    check({name, ".busy"}, busy, 0);
    check({name, ".timeout"}, timeout, exp_tmo);
    check({name, ".pass"}, pass, !exp_tmo && exp_err == 0);
    check({name, ".err_count"}, err_count, exp_err);
    check({name, ".first_idx"}, first_err_idx, exp_idx);
    check({name, ".first_exp"}, first_err_exp, exp_e);
    check({name, ".first_act"}, first_err_act, exp_a);
    pc = pc_pat[1100];
    @(posedge clk); #1;
    check({name, ".done_held"}, done, 1);
  endtask

  task automatic run_8(input string name);
    logic [7:0] f [0:N8-1];
    int done_c, exp_err, exp_idx;
    logic [7:0] exp_e, exp_a;
    f[0] = 1; f[1] = 1;
    for (int i = 2; i < N8; i++) f[i] = 8'((int'(f[i-1]) + int'(f[i-2])) % 256);
    exp_err = 0; exp_idx = 0; exp_e = 0; exp_a = 0;
    for (int i = 0; i < N8; i++)
      if (mem8[i] != f[i]) begin
        if (exp_err == 0) begin exp_idx = i; exp_e = f[i]; exp_a = mem8[i]; end
        exp_err++;
      end
    pc8 = HALT;
    start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    done_c = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (done8) begin done_c = c; break; end
    end
    check({name, ".done_cycle"}, done_c, STB + 1 + 2 * N8);
    check({name, ".pass"}, pass8, exp_err == 0);
    check({name, ".err_count"}, err_count8, exp_err);
    check({name, ".first_idx"}, first_err_idx8, exp_idx);
    check({name, ".first_exp"}, first_err_exp8, exp_e);
    check({name, ".first_act"}, first_err_act8, exp_a);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".done"}, done, 0);
    check({name, ".busy"}, busy, 0);
    check({name, ".pass"}, pass, 0);
    check({name, ".timeout"}, timeout, 0);
    check({name, ".rd_en"}, mem_rd_en, 0);
    check({name, ".rd_addr"}, mem_rd_addr, 0);
    check({name, ".err_count"}, err_count, 0);
    check({name, ".first_idx"}, first_err_idx, 0);
    check({name, ".first_exp"}, first_err_exp, 0);
    check({name, ".first_act"}, first_err_act, 0);
  endtask

  initial begin
    fill_mem();
    for (int i = 0; i < 256; i++) mem8[i] = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 0;
    @(posedge clk); #1;

    run_main("clean", 0);

    mem[3] = 4; mem[7] = 0;
    run_main("two_err", 0);
    fill_mem();

    run_main("toggle_tmo", 1);
    run_main("glitch", 2);

    for (int r = 0; r < 6; r++) begin
      fill_mem();
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        mem[$urandom_range(0, N - 1)] = $urandom;
      run_main($sformatf("rand%0d", r), 3);
    end
    fill_mem();

    // Reset while the idx-5 term is being checked, then rerun from scratch.
    pc = HALT;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (STB + 1 + 2 * 5 + 1) @(posedge clk);
    #1;
    check("mid.busy_before", busy, 1);
    reset = 1;
    @(posedge clk); #1;
    check_all_zero("mid_reset");
    reset = 0;
    run_main("after_reset", 0);

    begin
      logic [7:0] a, b, t;
      a = 1; b = 1;
      for (int i = 0; i < N8; i++) begin mem8[i] = a; t = a + b; a = b; b = t; end
    end
    run_8("wrap8");
    mem8[$urandom_range(2, N8 - 1)] = 8'($urandom_range(0, 255));
    mem8[$urandom_range(2, N8 - 1)] ^= 8'h10;
    run_8("wrap8_err");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
